// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// Imported by the interface, the storage array and the responder FSM.
package mips_mem_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned DEF_BASE_ADDR = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between the pipeline and the
// data-memory responder.
interface data_mem_responder_if;
    import mips_mem_pkg::*;

    logic            MEM_R_EN;
    logic            MEM_W_EN;
    logic [XLEN-1:0] Address;
    logic [XLEN-1:0] Write_data;
    logic            Mem_ready;
    logic [XLEN-1:0] Mem_read_value;
    logic            Addr_err;
    logic            freeze;

    modport master (
        output MEM_R_EN, MEM_W_EN, Address, Write_data,
        input  Mem_ready, Mem_read_value, Addr_err, freeze
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, Address, Write_data,
        output Mem_ready, Mem_read_value, Addr_err, freeze
    );

endinterface

// File: rtl/data_mem_array.sv
// Word-addressed data storage: synchronous write, combinational read.
// Contents are deliberately left unreset.
module data_mem_array
    import mips_mem_pkg::*;
#(
    parameter  int unsigned WORDS = 64,
    localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IW-1:0]   widx,
    input  logic [XLEN-1:0] wdata,
    input  logic [IW-1:0]   ridx,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: wait-state FSM, request latches,
// address checking and registered load result for the MEM stage.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned WORDS       = 64,
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);

    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [1:0]      rst_sync_q;
    logic            rst_n;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q;
    logic [IW-1:0]   idx_q;
    logic [XLEN-1:0] wdata_q;
    logic            err_q;
    logic [XLEN-1:0] rval_q;
    logic            aerr_q;

    logic            req;
    logic            in_idle;
    logic [29:0]     word;
    logic            in_err;
    logic            cur_wr;
    logic            cur_err;
    logic [IW-1:0]   cur_idx;
    logic [XLEN-1:0] cur_wdata;
    logic            enter_done;
    logic            we;
    logic [XLEN-1:0] rdata;

    // Asserts immediately, releases two clocks after rst goes high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    assign req     = bus.MEM_R_EN | bus.MEM_W_EN;
    assign in_idle = (state_q == IDLE);
    assign word    = 30'((bus.Address - BASE_ADDR) >> 2);
    assign in_err  = (bus.Address < BASE_ADDR)
                   | (word >= 30'(WORDS))
                   | (bus.Address[1:0] != 2'b00);

    // Zero wait states complete straight from IDLE on live inputs.
    assign cur_wr    = in_idle ? bus.MEM_W_EN   : wr_q;
    assign cur_err   = in_idle ? in_err         : err_q;
    assign cur_idx   = in_idle ? word[IW-1:0]   : idx_q;
    assign cur_wdata = in_idle ? bus.Write_data : wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign enter_done = (state_d == DONE) & (state_q != DONE);
    assign we         = enter_done & cur_wr & ~cur_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rval_q  <= '0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (in_idle && req) begin
                wr_q    <= bus.MEM_W_EN;
                idx_q   <= word[IW-1:0];
                wdata_q <= bus.Write_data;
                err_q   <= in_err;
            end
            if (enter_done) begin
                aerr_q <= cur_err;
                if (!cur_wr) begin
                    rval_q <= cur_err ? '0 : rdata;
                end
            end
        end
    end

    data_mem_array #(
        .WORDS (WORDS)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .widx  (cur_idx),
        .wdata (cur_wdata),
        .ridx  (cur_idx),
        .rdata (rdata)
    );

    assign bus.Mem_ready      = (state_q == DONE);
    assign bus.Mem_read_value = rval_q;
    assign bus.Addr_err       = aerr_q;
    assign bus.freeze         = req & ~bus.Mem_ready;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the MIPS pipeline's MEM stage. Accepts one read or write request at a time from the MEM stage and inserts a configurable number of wait states. While a request is pending it raises `freeze` so the pipeline registers hold. On completion it pulses `Mem_ready` and returns `Mem_read_value`, which the MEM/WB pipeline register captures for write-back.

## Interface
Parameters:
- `WORDS`, 64: data-memory depth in 32-bit words.
- `BASE_ADDR`, 1024: byte address of word 0.
- `WAIT_STATES`, 2: extra cycles between acceptance and completion, range 0..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low (0 = reset).
- `MEM_R_EN`  in  1: read request.
- `MEM_W_EN`  in  1: write request.
- `Address`  in  32: byte address.
- `Write_data`  in  32: store data.
- `Mem_ready`  out  1: one-cycle completion pulse.
- `Mem_read_value`  out  32: load result, registered.
- `Addr_err`  out  1: the completing request was out of range or misaligned. Valid with `Mem_ready`.
- `freeze`  out  1: pipeline hold request.

## Operation
- Request: `req = MEM_R_EN | MEM_W_EN`. If both are set, it is a write.
- Index: `idx = (Address - BASE_ADDR) >> 2`. Compute `Address - BASE_ADDR` as 32-bit unsigned.
- Error: an access is in error if `Address < BASE_ADDR`, `idx >= WORDS`, or `Address[1:0] != 0`.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: when `req` is high, latch op, idx, `Write_data` and the error flag. Load `cnt = WAIT_STATES`. Go to WAIT, or go straight to DONE if `WAIT_STATES == 0`. When `req` is low, stay in IDLE.
  - WAIT: decrement `cnt` each cycle. When `cnt == 1`, go to DONE.
  - DONE: `Mem_ready = 1`. Unconditionally return to IDLE.
- On the edge that enters DONE:
  - Write without error: update array[idx].
  - Read without error: `Mem_read_value <= array[idx]`.
  - Read with error: `Mem_read_value <= 0`.
  - Write (with or without error): `Mem_read_value` unchanged.
  - Erroneous write: no array update.
- `Addr_err` is registered alongside the state. It is meaningful only while `Mem_ready` is high.
- `freeze = req & ~Mem_ready`, combinational.
- Inputs sampled after acceptance are ignored until the state returns to IDLE.
- The initiator holds the request stable while `freeze` is high. In the cycle after `Mem_ready`, the pipeline has advanced, so any request present in IDLE is a new request.

## Timing
- Reset (async assert, sync deassert inside block):
  - state = IDLE, `cnt = 0`.
  - `Mem_ready = 0`, `Mem_read_value = 0`, `Addr_err = 0`.
  - `freeze` follows `req`.
- The memory array is not reset.
- Latency: request accepted on edge E0; `Mem_ready` is high during cycle E0+WAIT_STATES+1.
  - `WAIT_STATES = 0`: 1-cycle latency.
  - Default: 3 cycles.
- Back-to-back: a request present in the cycle following DONE is accepted immediately. Throughput is one access per WAIT_STATES+2 cycles.
- Reset mid-WAIT: the pending access is dropped, a pending write is not performed, and there is no `Mem_ready` pulse.
- `Mem_ready` is never high for two consecutive cycles.

## Structure
- Package `mips_mem_pkg`: state enum (IDLE/WAIT/DONE), `BASE_ADDR` default, word-width constant.
- Sub-module `data_mem_array`:
  - `WORDS` x 32.
  - Synchronous write (`we`, `widx`, `wdata`).
  - Combinational read (`ridx` -> `rdata`).
  - No reset.
- The responder holds the FSM, counter, request latches, error check and output registers.

## Test plan
- Reset behaviour: drive `rst = 0` asynchronously mid-cycle -> all outputs go to 0 immediately. `freeze` = 1 if `MEM_R_EN = 1`.
- Write then read: write 0xDEADBEEF to 1032, then read 1032 -> `Mem_ready` at cycle +3 for each access. Read returns 0xDEADBEEF with `Addr_err = 0`. `freeze` is high for 3 cycles of each access.
- Error cases: read 1020 -> `Mem_read_value = 0`, `Addr_err = 1`. Write 1026 -> `Addr_err = 1` and array[0..63] unchanged. Write to 1024+4·64 -> `Addr_err = 1`.
- Simultaneous R/W to 1028 with data 0x5 -> treated as write. `Mem_read_value` retains its prior value; a subsequent read returns 0x5.
- Reset mid-operation: write 0x1234 to 1040, assert reset during WAIT -> no `Mem_ready` pulse. A read of 1040 after reset returns the old contents.
- `WAIT_STATES = 0`: back-to-back reads of 1024 and 1028 -> `Mem_ready` pulses 2 cycles apart, each 1 cycle after acceptance.
